// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte producers.
// Each grant reserves a fixed frame time because the transmitter reports neither busy nor done.
module uart_tx_sched #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = 176,
    parameter int EN_CYCLES    = 4
) (
    input  logic                       fpga_clk,
    input  logic                       rst,
    input  logic                       pause,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       tx_en,
    output logic [7:0]                 din,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [15:0]                sent_cnt
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(FRAME_CYCLES);

    // Handshake: req is a level held by the producer; ack is a one-cycle pulse in the
    // first SEND cycle, after which the producer may drop or change req and its byte.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         din_q, din_d;
    logic               busy_q, busy_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [15:0]        sent_q, sent_d;

    logic               found;
    logic [IDW-1:0]     winner;
    logic [IDW:0]       sum;
    logic [IDW-1:0]     cand;

    // Rotating priority search starting at ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NUM_REQ)) begin
                sum = sum - (IDW+1)'(NUM_REQ);
            end
            cand = sum[IDW-1:0];
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        tx_en_d = 1'b0;
        din_d   = din_q;
        gid_d   = gid_q;
        sent_d  = sent_q;
        case (state_q)
            IDLE: begin
                if (!pause && found) begin
                    state_d     = SEND;
                    cnt_d       = '0;
                    ptr_d       = (winner == IDW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
                    ack_d[winner] = 1'b1;
                    tx_en_d     = 1'b1;
                    din_d       = req_data[{winner, 3'b000} +: 8];
                    gid_d       = winner;
                    sent_d      = sent_q + 16'd1;
                end
            end
            SEND: begin
                if (cnt_q == CW'(FRAME_CYCLES-1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    tx_en_d = (int'(cnt_q) + 1 < EN_CYCLES);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SEND);
    end

    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
            tx_en_q <= 1'b0;
            din_q   <= 8'h00;
            busy_q  <= 1'b0;
            gid_q   <= '0;
            sent_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            tx_en_q <= tx_en_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            gid_q   <= gid_d;
            sent_q  <= sent_d;
        end
    end

    assign ack      = ack_q;
    assign tx_en    = tx_en_q;
    assign din      = din_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;
    assign sent_cnt = sent_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus random traffic, compared every cycle
// against a time-arithmetic reference model of the grant schedule.
module tb_uart_tx_sched;
    localparam int NR = 4;
    localparam int FC = 176;
    localparam int EC = 4;

    logic              fpga_clk = 1'b0;
    logic              rst;
    logic              pause;
    logic [NR-1:0]     req;
    logic [8*NR-1:0]   req_data;
    logic [NR-1:0]     ack;
    logic              tx_en;
    logic [7:0]        din;
    logic              busy;
    logic [1:0]        grant_id;
    logic [15:0]       sent_cnt;

    uart_tx_sched #(
        .NUM_REQ      (NR),
        .FRAME_CYCLES (FC),
        .EN_CYCLES    (EC)
    ) dut (
        .fpga_clk (fpga_clk),
        .rst      (rst),
        .pause    (pause),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_en    (tx_en),
        .din      (din),
        .busy     (busy),
        .grant_id (grant_id),
        .sent_cnt (sent_cnt)
    );

    always #5 fpga_clk = ~fpga_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: a frame occupies the FC cycles after its grant edge.
    int          edge_n = 0;
    int          last_g = 0;
    bit          have_g = 0;
    int          m_ptr  = 0;
    logic [7:0]  m_din  = 8'h00;
    int          m_gid  = 0;
    logic [15:0] m_sent = 16'h0000;
    logic [7:0]  exp_q[$];

    // Observations from the DUT side, used by the directed scenarios.
    int ack_ids[$];
    int ack_edges[$];
    int tx_high = 0;
    int busy_high = 0;

    task automatic model_reset();
        have_g = 0;
        m_ptr  = 0;
        m_din  = 8'h00;
        m_gid  = 0;
        m_sent = 16'h0000;
        exp_q.delete();
    endtask

    task automatic model_edge();
        int w;
        edge_n++;
        if (rst) begin
            model_reset();
            return;
        end
        if ((!have_g || edge_n - last_g >= FC + 1) && !pause && req != '0) begin
            w = -1;
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (w < 0 && req[i]) w = i;
            end
            m_din  = req_data[8*w +: 8];
            m_gid  = w;
            m_ptr  = (w + 1) % NR;
            m_sent = m_sent + 16'd1;
            last_g = edge_n;
            have_g = 1;
            exp_q.push_back(m_din);
        end
    endtask

    task automatic check_outputs();
        int d;
        logic [31:0] exp_ack;
        d = edge_n - last_g;
        exp_ack = (have_g && d == 0) ? (32'd1 << m_gid) : 32'd0;
        check_eq("ack", 32'(ack), exp_ack);
        check_eq("tx_en", 32'(tx_en), 32'(have_g && d < EC));
        check_eq("busy", 32'(busy), 32'(have_g && d < FC));
        check_eq("din", 32'(din), 32'(m_din));
        check_eq("grant_id", 32'(grant_id), 32'(m_gid));
        check_eq("sent_cnt", 32'(sent_cnt), 32'(m_sent));
        if (ack != '0) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_extra_ack", 32'(ack), 32'd0);
            end else begin
                check_eq("sb_din", 32'(din), 32'(exp_q.pop_front()));
            end
            for (int i = 0; i < NR; i++) begin
                if (ack[i]) ack_ids.push_back(i);
            end
            ack_edges.push_back(edge_n);
        end
        if (tx_en) tx_high++;
        if (busy) busy_high++;
    endtask

    task automatic tick();
        @(posedge fpga_clk);
        model_edge();
        @(negedge fpga_clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_obs();
        ack_ids.delete();
        ack_edges.delete();
        tx_high = 0;
        busy_high = 0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_order(input string tag, input int exp_ids[$]);
        check_eq({tag, "_len"}, 32'(ack_ids.size()), 32'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size() && i < ack_ids.size(); i++) begin
            check_eq(tag, 32'(ack_ids[i]), 32'(exp_ids[i]));
        end
    endtask

    initial begin
        int fall_edge;
        bit seen_ack;
        rst      = 1'b1;
        pause    = 1'b0;
        req      = '0;
        req_data = '0;
        #1;
        model_reset();
        check_outputs();
        reset_dut();

        // Single byte from requester 0.
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        clear_obs();
        tick();
        check_eq("first_ack", 32'(ack), 32'h1);
        check_eq("first_din", 32'(din), 32'hA5);
        req = '0;
        run(200);
        check_eq("first_tx_len", 32'(tx_high), EC);
        check_eq("first_busy_len", 32'(busy_high), FC);
        check_eq("first_ack_cnt", 32'(ack_edges.size()), 32'd1);
        check_eq("first_sent", 32'(sent_cnt), 32'd1);

        // All requesters held: strict rotation with FC+1 spacing.
        reset_dut();
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        req = 4'b1111;
        clear_obs();
        run(4 * (FC + 1) + 1);
        req = '0;
        check_order("rr_order", '{0, 1, 2, 3, 0});
        for (int i = 1; i < ack_edges.size(); i++) begin
            check_eq("rr_spacing", 32'(ack_edges[i] - ack_edges[i-1]), FC + 1);
        end
        run(FC + 5);

        // Pointer past requester 1: only 3 and 1 compete.
        reset_dut();
        req = 4'b0010;
        tick();
        req = 4'b1010;
        clear_obs();
        run(3 * (FC + 1));
        req = '0;
        check_order("skip_order", '{3, 1, 3});
        run(FC + 5);

        // Request raised mid-frame waits for the IDLE cycle.
        req = 4'b0001;
        tick();
        req = '0;
        run(49);
        req = 4'b0100;
        clear_obs();
        fall_edge = -1;
        seen_ack = 0;
        for (int i = 0; i < 400 && !seen_ack; i++) begin
            tick();
            if (!busy && fall_edge < 0) fall_edge = edge_n;
            if (ack != '0) seen_ack = 1;
        end
        check_eq("late_req_acked", 32'(seen_ack), 32'd1);
        if (ack_edges.size() > 0) begin
            check_eq("late_req_edge", 32'(ack_edges[0]), 32'(fall_edge + 1));
            check_eq("late_req_id", 32'(ack_ids[0]), 32'd2);
        end
        req = '0;
        run(FC + 5);

        // Pause blocks grants; pause mid-frame does not disturb the frame.
        pause = 1'b1;
        req = 4'b0100;
        clear_obs();
        run(300);
        check_eq("pause_no_ack", 32'(ack_edges.size()), 32'd0);
        check_eq("pause_no_tx", 32'(tx_high), 32'd0);
        pause = 1'b0;
        clear_obs();
        tick();
        check_eq("pause_release_ack", 32'(ack), 32'h4);
        req = '0;
        run(10);
        pause = 1'b1;
        run(170);
        check_eq("pause_mid_busy", 32'(busy_high), FC);
        check_eq("pause_mid_tx", 32'(tx_high), EC);
        pause = 1'b0;

        // Asynchronous reset mid-frame, then counter wrap.
        req = 4'b0001;
        tick();
        req = '0;
        run(19);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check_eq("async_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        force dut.sent_q = 16'hFFFF;
        #1;
        release dut.sent_q;
        m_sent = 16'hFFFF;
        #1;
        check_eq("preload", 32'(sent_cnt), 32'hFFFF);
        req = 4'b0001;
        tick();
        req = '0;
        check_eq("wrap", 32'(sent_cnt), 32'h0000);
        run(FC + 5);

        // Random traffic.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 14) == 0) req = NR'($urandom);
            if ($urandom_range(0, 39) == 0) pause = ~pause;
            if ($urandom_range(0, 7) == 0) req_data = {$urandom, $urandom};
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
